// File: rtl/llc_update_seq_if.sv
// llc_update_seq_if
//   Groups the command handshake from the LLC controller and the array
//   write-port bus driven by the update sequencer.
//   master : command source / array side (drives req_*, state/hprot buffers,
//            arr_stall; observes req_ready, wr_*, done, flush_count)
//   slave  : the sequencer (llc_update_seq)
interface llc_update_seq_if #(
  parameter int WAYS         = 16,
  parameter int PORTS        = 4,
  parameter int SET_BITS     = 8,
  parameter int TAG_BITS     = 20,
  parameter int LINE_BITS    = 128,
  parameter int STATE_BITS   = 3,
  parameter int HPROT_BITS   = 1,
  parameter int SHARERS_BITS = 16,
  parameter int OWNER_BITS   = 4
);
  localparam int NG = WAYS / PORTS;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  // command side
  logic                       req_valid;
  logic                       req_ready;
  logic [1:0]                 req_mode;
  logic [SET_BITS-1:0]        req_set;
  logic [WW-1:0]              req_way;
  logic [TAG_BITS-1:0]        req_tag;
  logic [LINE_BITS-1:0]       req_line;
  logic [STATE_BITS-1:0]      req_state;
  logic [HPROT_BITS-1:0]      req_hprot;
  logic [OWNER_BITS-1:0]      req_owner;
  logic [SHARERS_BITS-1:0]    req_sharers;
  logic                       req_dirty;
  logic [WW-1:0]              req_evict_way;
  logic                       req_update_evict;
  logic [WAYS*STATE_BITS-1:0] states_buf;
  logic [WAYS*HPROT_BITS-1:0] hprots_buf;

  // array side
  logic                       arr_stall;
  logic [SET_BITS-1:0]        wr_set;
  logic [GW-1:0]              wr_group;
  logic [PORTS-1:0]           wr_port_en;
  logic [TAG_BITS-1:0]        wr_data_tag;
  logic [LINE_BITS-1:0]       wr_data_line;
  logic [STATE_BITS-1:0]      wr_data_state;
  logic [HPROT_BITS-1:0]      wr_data_hprot;
  logic [OWNER_BITS-1:0]      wr_data_owner;
  logic [SHARERS_BITS-1:0]    wr_data_sharers;
  logic                       wr_data_dirty;
  logic                       wr_en_evict_way;
  logic [WW-1:0]              wr_data_evict_way;

  // status
  logic                       done;
  logic [WW:0]                flush_count;

  modport master (
    output req_valid, req_mode, req_set, req_way, req_tag, req_line, req_state,
           req_hprot, req_owner, req_sharers, req_dirty, req_evict_way,
           req_update_evict, states_buf, hprots_buf, arr_stall,
    input  req_ready, wr_set, wr_group, wr_port_en, wr_data_tag, wr_data_line,
           wr_data_state, wr_data_hprot, wr_data_owner, wr_data_sharers,
           wr_data_dirty, wr_en_evict_way, wr_data_evict_way, done, flush_count
  );

  modport slave (
    input  req_valid, req_mode, req_set, req_way, req_tag, req_line, req_state,
           req_hprot, req_owner, req_sharers, req_dirty, req_evict_way,
           req_update_evict, states_buf, hprots_buf, arr_stall,
    output req_ready, wr_set, wr_group, wr_port_en, wr_data_tag, wr_data_line,
           wr_data_state, wr_data_hprot, wr_data_owner, wr_data_sharers,
           wr_data_dirty, wr_en_evict_way, wr_data_evict_way, done, flush_count
  );
endinterface

// File: rtl/llc_update_seq.sv
// llc_update_seq
//   Multi-beat write-back sequencer between the LLC controller and the LLC
//   tag/state/data arrays. One command is accepted per handshake and written
//   to the arrays PORTS ways per beat.
//   Commands (req_mode): 0 WAY_WB single way, 1 RST whole set,
//                        2 FLUSH eligible ways of a set, 3 RST_ALL every set.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : llc_update_seq_if.slave (command handshake, array write
//                beat outputs, arr_stall back-pressure, done pulse,
//                flush_count of the last FLUSH)
//   All beat outputs are registered; the first beat appears the cycle after
//   acceptance, and a beat advances on every cycle with arr_stall low.
module llc_update_seq #(
  parameter int WAYS         = 16,
  parameter int PORTS        = 4,
  parameter int SET_BITS     = 8,
  parameter int TAG_BITS     = 20,
  parameter int LINE_BITS    = 128,
  parameter int STATE_BITS   = 3,
  parameter int HPROT_BITS   = 1,
  parameter int SHARERS_BITS = 16,
  parameter int OWNER_BITS   = 4,
  parameter int STATE_VALID  = 1,
  parameter int HPROT_DATA   = 1
) (
  input logic             clk,
  input logic             rst,
  llc_update_seq_if.slave bus
);
  localparam int NG = WAYS / PORTS;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PB = (PORTS > 1) ? $clog2(PORTS) : 0;

  localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

  localparam logic [1:0] M_WAY_WB  = 2'd0;
  localparam logic [1:0] M_RST     = 2'd1;
  localparam logic [1:0] M_FLUSH   = 2'd2;
  localparam logic [1:0] M_RST_ALL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [SET_BITS-1:0]     set_q, set_d;
  logic [GW-1:0]           group_q, group_d;
  logic [PORTS-1:0]        port_en_q, port_en_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic [LINE_BITS-1:0]    line_q, line_d;
  logic [STATE_BITS-1:0]   st_q, st_d;
  logic [HPROT_BITS-1:0]   hprot_q, hprot_d;
  logic [OWNER_BITS-1:0]   owner_q, owner_d;
  logic [SHARERS_BITS-1:0] sharers_q, sharers_d;
  logic                    dirty_q, dirty_d;
  logic                    ev_en_q, ev_en_d;
  logic [WW-1:0]           ev_way_q, ev_way_d;
  logic [WAYS-1:0]         elig_q, elig_d;
  logic [WW:0]             fc_q, fc_d;
  logic                    done_q, done_d;

  // Flush eligibility of the incoming buffers and per-group occupancy,
  // both for the live request and for the mask captured at acceptance.
  logic [WAYS-1:0] elig_in;
  logic [NG-1:0]   any_in;
  logic [NG-1:0]   any_q;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_elig
      assign elig_in[gi] =
        (bus.states_buf[gi*STATE_BITS +: STATE_BITS] == STATE_BITS'(STATE_VALID)) &&
        (bus.hprots_buf[gi*HPROT_BITS +: HPROT_BITS] == HPROT_BITS'(HPROT_DATA));
    end
    for (gi = 0; gi < NG; gi++) begin : g_any
      assign any_in[gi] = |elig_in[gi*PORTS +: PORTS];
      assign any_q[gi]  = |elig_q[gi*PORTS +: PORTS];
    end
  endgenerate

  // Lowest non-empty group at or above lo; MSB of the result flags a hit.
  function automatic logic [GW:0] find_group(input logic [NG-1:0] any, input int lo);
    logic [GW:0] r;
    r = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (g >= lo && any[g]) r = {1'b1, GW'(g)};
    end
    return r;
  endfunction

  function automatic logic [WW:0] popcount(input logic [WAYS-1:0] v);
    logic [WW:0] c;
    c = '0;
    for (int i = 0; i < WAYS; i++) c = c + (WW+1)'(v[i]);
    return c;
  endfunction

  logic          finish;
  logic [GW:0]   hit;
  logic [WW-1:0] port_idx;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    set_d     = set_q;
    group_d   = group_q;
    port_en_d = port_en_q;
    tag_d     = tag_q;
    line_d    = line_q;
    st_d      = st_q;
    hprot_d   = hprot_q;
    owner_d   = owner_q;
    sharers_d = sharers_q;
    dirty_d   = dirty_q;
    ev_en_d   = ev_en_q;
    ev_way_d  = ev_way_q;
    elig_d    = elig_q;
    fc_d      = fc_q;
    done_d    = 1'b0;
    finish    = 1'b0;
    hit       = '0;
    port_idx  = '0;

    // Data outputs are already zero in IDLE (cleared on every finish and by
    // reset), so RST/FLUSH/RST_ALL only need to set enables here.
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          mode_d  = bus.req_mode;
          set_d   = bus.req_set;
          group_d = '0;
          elig_d  = '0;
          case (bus.req_mode)
            M_WAY_WB: begin
              state_d   = S_BEAT;
              group_d   = GW'(bus.req_way >> PB);
              port_idx  = bus.req_way & WW'(PORTS - 1);
              port_en_d = PORTS'(1) << port_idx;
              tag_d     = bus.req_tag;
              line_d    = bus.req_line;
              st_d      = bus.req_state;
              hprot_d   = bus.req_hprot;
              owner_d   = bus.req_owner;
              sharers_d = bus.req_sharers;
              dirty_d   = bus.req_dirty;
              ev_en_d   = bus.req_update_evict;
              ev_way_d  = bus.req_evict_way;
            end
            M_FLUSH: begin
              elig_d = elig_in;
              hit    = find_group(any_in, 0);
              if (hit[GW]) begin
                state_d   = S_BEAT;
                group_d   = hit[GW-1:0];
                port_en_d = elig_in[int'(hit[GW-1:0])*PORTS +: PORTS];
              end else begin
                // Nothing to invalidate: straight to DONE with zero beats.
                finish = 1'b1;
                fc_d   = '0;
              end
            end
            default: begin
              // RST and RST_ALL start at group 0 with the evict-way reset.
              state_d   = S_BEAT;
              if (bus.req_mode == M_RST_ALL) set_d = '0;
              port_en_d = '1;
              ev_en_d   = 1'b1;
              ev_way_d  = '0;
            end
          endcase
        end
      end

      S_BEAT: begin
        if (!bus.arr_stall) begin
          case (mode_q)
            M_WAY_WB: finish = 1'b1;
            M_FLUSH: begin
              hit = find_group(any_q, int'(group_q) + 1);
              if (hit[GW]) begin
                group_d   = hit[GW-1:0];
                port_en_d = elig_q[int'(hit[GW-1:0])*PORTS +: PORTS];
              end else begin
                finish = 1'b1;
                fc_d   = popcount(elig_q);
              end
            end
            default: begin
              ev_en_d = 1'b0;
              if (group_q != LAST_G) begin
                group_d = group_q + 1'b1;
              end else if (mode_q == M_RST_ALL && !(&set_q)) begin
                // Next set restarts at group 0, with its own evict-way reset.
                set_d   = set_q + 1'b1;
                group_d = '0;
                ev_en_d = 1'b1;
              end else begin
                finish = 1'b1;
              end
            end
          endcase
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      port_en_d = '0;
      tag_d     = '0;
      line_d    = '0;
      st_d      = '0;
      hprot_d   = '0;
      owner_d   = '0;
      sharers_d = '0;
      dirty_d   = 1'b0;
      ev_en_d   = 1'b0;
      ev_way_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      set_q     <= '0;
      group_q   <= '0;
      port_en_q <= '0;
      tag_q     <= '0;
      line_q    <= '0;
      st_q      <= '0;
      hprot_q   <= '0;
      owner_q   <= '0;
      sharers_q <= '0;
      dirty_q   <= 1'b0;
      ev_en_q   <= 1'b0;
      ev_way_q  <= '0;
      elig_q    <= '0;
      fc_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      set_q     <= set_d;
      group_q   <= group_d;
      port_en_q <= port_en_d;
      tag_q     <= tag_d;
      line_q    <= line_d;
      st_q      <= st_d;
      hprot_q   <= hprot_d;
      owner_q   <= owner_d;
      sharers_q <= sharers_d;
      dirty_q   <= dirty_d;
      ev_en_q   <= ev_en_d;
      ev_way_q  <= ev_way_d;
      elig_q    <= elig_d;
      fc_q      <= fc_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready         = (state_q == S_IDLE);
  assign bus.wr_set            = set_q;
  assign bus.wr_group          = group_q;
  assign bus.wr_port_en        = port_en_q;
  assign bus.wr_data_tag       = tag_q;
  assign bus.wr_data_line      = line_q;
  assign bus.wr_data_state     = st_q;
  assign bus.wr_data_hprot     = hprot_q;
  assign bus.wr_data_owner     = owner_q;
  assign bus.wr_data_sharers   = sharers_q;
  assign bus.wr_data_dirty     = dirty_q;
  assign bus.wr_en_evict_way   = ev_en_q;
  assign bus.wr_data_evict_way = ev_way_q;
  assign bus.done              = done_q;
  assign bus.flush_count       = fc_q;
endmodule

// File: tb/tb_llc_update_seq.sv
// tb_llc_update_seq
//   Scoreboard bench for llc_update_seq (WAYS=16, PORTS=4, SET_BITS=2).
//   Stimulus pushes the expected beat/done records (with the cycle they must
//   appear on); a separate monitor pops and compares whenever the DUT shows a
//   beat, an evict-way write or a done pulse.
module tb_llc_update_seq;
  localparam int SB = 2;
  localparam logic [1:0] M_WAY_WB  = 2'd0;
  localparam logic [1:0] M_RST     = 2'd1;
  localparam logic [1:0] M_FLUSH   = 2'd2;
  localparam logic [1:0] M_RST_ALL = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_update_seq_if #(.SET_BITS(SB)) bus ();
  llc_update_seq #(.SET_BITS(SB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int           cyc;
    bit           is_done;
    logic [1:0]   set;
    logic [1:0]   grp;
    logic [3:0]   en;
    logic [19:0]  tag;
    logic [127:0] line;
    logic [2:0]   st;
    logic         hp;
    logic [3:0]   own;
    logic [15:0]  sh;
    logic         dirty;
    logic         ev_en;
    logic [3:0]   ev_way;
    logic [4:0]   fc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_beat(input int c, input logic [1:0] s, input logic [1:0] g,
                           input logic [3:0] en, input logic ev, input logic [3:0] evw);
    exp_t e;
    e = '{default: 0};
    e.cyc = c; e.set = s; e.grp = g; e.en = en; e.ev_en = ev; e.ev_way = evw;
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [4:0] fc);
    exp_t e;
    e = '{default: 0};
    e.cyc = c; e.is_done = 1'b1; e.fc = fc;
    q.push_back(e);
  endtask

  // Waits (bounded) for req_ready at a falling edge and raises req_valid.
  // a = cycle number on which the first beat (or done) must be visible.
  task automatic start(input logic [1:0] mode, input logic [1:0] set, output int a);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", bus.req_ready, 1);
    bus.req_mode  = mode;
    bus.req_set   = set;
    bus.req_valid = 1'b1;
    a = cyc + 1;
  endtask

  task automatic release_req();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_all_expected_seen"}, q.size(), 0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    check({name, "_req_ready"},   bus.req_ready, 1);
    check({name, "_done"},        bus.done, 0);
    check({name, "_port_en"},     bus.wr_port_en, 0);
    check({name, "_en_evict"},    bus.wr_en_evict_way, 0);
    check({name, "_evict_way"},   bus.wr_data_evict_way, 0);
    check({name, "_wr_set"},      bus.wr_set, 0);
    check({name, "_wr_group"},    bus.wr_group, 0);
    check({name, "_line"},        bus.wr_data_line, 0);
    check({name, "_fields"},      {bus.wr_data_tag, bus.wr_data_state, bus.wr_data_hprot,
                                   bus.wr_data_owner, bus.wr_data_sharers, bus.wr_data_dirty}, 0);
    check({name, "_flush_count"}, bus.flush_count, 0);
  endtask

  // Monitor: one comparison group per observed transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && (bus.done || bus.wr_port_en != 4'd0 || bus.wr_en_evict_way)) begin
        $display("obs cyc=%0d done=%0b set=%0d grp=%0d en=%b ev=%0b/%0d fc=%0d",
                 cyc, bus.done, bus.wr_set, bus.wr_group, bus.wr_port_en,
                 bus.wr_en_evict_way, bus.wr_data_evict_way, bus.flush_count);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got done=%0b en=%b at cyc %0d, required no activity",
                   bus.done, bus.wr_port_en, cyc);
        end else begin
          e = q.pop_front();
          check("txn_cycle",   cyc, e.cyc);
          check("txn_done",    bus.done, e.is_done);
          check("txn_port_en", bus.wr_port_en, e.en);
          check("txn_line",    bus.wr_data_line, e.line);
          check("txn_fields",  {bus.wr_data_tag, bus.wr_data_state, bus.wr_data_hprot,
                                bus.wr_data_owner, bus.wr_data_sharers, bus.wr_data_dirty},
                               {e.tag, e.st, e.hp, e.own, e.sh, e.dirty});
          check("txn_evict",   {bus.wr_en_evict_way, bus.wr_data_evict_way}, {e.ev_en, e.ev_way});
          if (e.is_done) begin
            check("txn_flush_count", bus.flush_count, e.fc);
          end else begin
            check("txn_set_group", {bus.wr_set, bus.wr_group}, {e.set, e.grp});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int dones;
    exp_t e;
    bus.req_valid = 1'b0; bus.req_mode = '0; bus.req_set = '0; bus.req_way = '0;
    bus.req_tag = '0; bus.req_line = '0; bus.req_state = '0; bus.req_hprot = '0;
    bus.req_owner = '0; bus.req_sharers = '0; bus.req_dirty = 1'b0;
    bus.req_evict_way = '0; bus.req_update_evict = 1'b0;
    bus.states_buf = '0; bus.hprots_buf = '0; bus.arr_stall = 1'b0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;

    // WAY_WB way 6 -> group 1, port 2, evict write 7, done next cycle.
    bus.req_way = 4'd6; bus.req_tag = 20'h12345;
    bus.req_line = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    bus.req_state = 3'd1; bus.req_hprot = 1'b1; bus.req_owner = 4'h9;
    bus.req_sharers = 16'hA5A5; bus.req_dirty = 1'b1;
    bus.req_evict_way = 4'd7; bus.req_update_evict = 1'b1;
    start(M_WAY_WB, 2'd2, a);
    e = '{default: 0};
    e.cyc = a; e.set = 2'd2; e.grp = 2'd1; e.en = 4'b0100; e.tag = 20'h12345;
    e.line = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210; e.st = 3'd1; e.hp = 1'b1;
    e.own = 4'h9; e.sh = 16'hA5A5; e.dirty = 1'b1; e.ev_en = 1'b1; e.ev_way = 4'd7;
    q.push_back(e);
    push_done(a + 1, 5'd0);
    release_req();
    check("ready_low_in_beat", bus.req_ready, 0);
    drain("way_wb");

    // RST with a 2-cycle stall on beat 2: groups 0,1,2,2,2,3 then done.
    start(M_RST, 2'd1, a);
    push_beat(a,     2'd1, 2'd0, 4'hF, 1'b1, 4'd0);
    push_beat(a + 1, 2'd1, 2'd1, 4'hF, 1'b0, 4'd0);
    push_beat(a + 2, 2'd1, 2'd2, 4'hF, 1'b0, 4'd0);
    push_beat(a + 3, 2'd1, 2'd2, 4'hF, 1'b0, 4'd0);
    push_beat(a + 4, 2'd1, 2'd2, 4'hF, 1'b0, 4'd0);
    push_beat(a + 5, 2'd1, 2'd3, 4'hF, 1'b0, 4'd0);
    push_done(a + 6, 5'd0);
    release_req();
    @(negedge clk);
    @(negedge clk);
    bus.arr_stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.arr_stall = 1'b0;
    drain("rst_stall");

    // FLUSH with nothing eligible (VALID everywhere but hprot 0), stall held
    // high across IDLE and DONE: done the cycle after accept, count 0.
    for (int w = 0; w < 16; w++) bus.states_buf[w*3 +: 3] = 3'd1;
    bus.hprots_buf = '0;
    bus.arr_stall = 1'b1;
    start(M_FLUSH, 2'd0, a);
    push_done(a, 5'd0);
    release_req();
    check("ready_low_in_done", bus.req_ready, 0);
    @(negedge clk);
    bus.arr_stall = 1'b0;
    drain("flush_empty");

    // FLUSH: eligible ways 1,2,13; way 5 VALID/hprot 0; way 8 state 2/hprot 1.
    bus.states_buf = '0;
    bus.states_buf[1*3 +: 3] = 3'd1;
    bus.states_buf[2*3 +: 3] = 3'd1;
    bus.states_buf[13*3 +: 3] = 3'd1;
    bus.states_buf[5*3 +: 3] = 3'd1;
    bus.states_buf[8*3 +: 3] = 3'd2;
    bus.hprots_buf = 16'b0010_0001_0000_0110;
    start(M_FLUSH, 2'd3, a);
    push_beat(a,     2'd3, 2'd0, 4'b0110, 1'b0, 4'd0);
    push_beat(a + 1, 2'd3, 2'd3, 4'b0010, 1'b0, 4'd0);
    push_done(a + 2, 5'd3);
    release_req();
    drain("flush");

    // RST_ALL: 4 sets x 4 groups, evict reset at group 0 of every set.
    start(M_RST_ALL, 2'd2, a);
    for (int i = 0; i < 16; i++)
      push_beat(a + i, 2'(i / 4), 2'(i % 4), 4'hF, (i % 4) == 0, 4'd0);
    push_done(a + 16, 5'd3);
    release_req();
    drain("rst_all");

    // Abort RST_ALL by reset after 5 beats: immediate reset values, no done.
    start(M_RST_ALL, 2'd1, a);
    for (int i = 0; i < 16; i++)
      push_beat(a + i, 2'(i / 4), 2'(i % 4), 4'hF, (i % 4) == 0, 4'd0);
    push_done(a + 16, 5'd3);
    release_req();
    repeat (4) @(negedge clk);
    check("flush_count_before_abort", bus.flush_count, 3);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    check_reset("abort");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_abort", bus.req_ready, 1);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("no_done_after_abort", dones, 0);

    // WAY_WB way 15 without evict update after the abort.
    bus.req_way = 4'd15; bus.req_tag = 20'hABCDE; bus.req_line = 128'h5;
    bus.req_state = 3'd2; bus.req_hprot = 1'b0; bus.req_owner = 4'h3;
    bus.req_sharers = 16'h0101; bus.req_dirty = 1'b0;
    bus.req_evict_way = 4'd9; bus.req_update_evict = 1'b0;
    start(M_WAY_WB, 2'd3, a);
    e = '{default: 0};
    e.cyc = a; e.set = 2'd3; e.grp = 2'd3; e.en = 4'b1000; e.tag = 20'hABCDE;
    e.line = 128'h5; e.st = 3'd2; e.hp = 1'b0; e.own = 4'h3; e.sh = 16'h0101;
    e.dirty = 1'b0; e.ev_en = 1'b0; e.ev_way = 4'd9;
    q.push_back(e);
    push_done(a + 1, 5'd0);
    release_req();
    drain("way_wb_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
